inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch unit: drives PC into the instruction ROM (InstROM, combinational read) and
//  captures the returned word into an instruction register (IR) for decode/execute. Owns
//  sequencing: start, sequential advance, absolute/relative branch redirect, stall, halt detect.
//  Sits between InstROM and the decode stage of the 9-bit-instruction core.
// PARAMETERS
//  A          10       PC / ROM address width (ROM depth 2**A)
//  W          9        instruction width
//  START_ADDR 0        PC value loaded on reset and on every Start
//  HALT_WORD  9'h1FF   instruction encoding that terminates the program
// PORTS
//  Clk       in   1  clock, all state on rising edge
//  Reset     in   1  asynchronous, active-high reset
//  Start     in   1  1-cycle pulse: begin execution at START_ADDR (honoured in IDLE/HALT only)
//  Stall     in   1  downstream not ready: hold PC, IR, IRPC, IRValid
//  BrTaken   in   1  execute resolved a taken branch for the instruction currently in IR
//  BrAbs     in   1  1: BrTarget is absolute address; 0: BrTarget is signed offset from IRPC
//  BrTarget  in   A  branch address or two's-complement offset
//  Inst      in   W  instruction word from ROM at PC (same cycle)
//  PC        out  A  ROM address
//  IR        out  W  registered instruction
//  IRPC      out  A  address IR was fetched from
//  IRValid   out  1  IR holds a live instruction
//  Busy      out  1  state == RUN
//  Done      out  1  state == HALT
// BEHAVIOUR
//  Reset (any time, incl. mid-run): state=IDLE, PC=START_ADDR, IR=0, IRPC=0, IRValid=0,
//    Busy=0, Done=0; perf counters (if built) = 0.
//  States IDLE, RUN, HALT. IDLE--Start-->RUN; RUN--halt fetched-->HALT; HALT--Start-->RUN.
//  Entering RUN: PC=START_ADDR, IRValid=0, Done=0. Start while in RUN is ignored.
//  RUN, per cycle, priority BrTaken&IRValid&!Stall > Stall > halt detect > normal:
//   - normal: IR<=Inst, IRPC<=PC, IRValid<=1, PC<=PC+1. Fetch-to-IR latency 1 cycle.
//   - Stall=1: all registers hold; BrTaken ignored (execute is held too).
//   - branch: PC<=BrAbs ? BrTarget : IRPC+BrTarget (mod 2**A); IRValid<=0 (word at old PC
//     squashed, 1-cycle bubble); a HALT_WORD on Inst that cycle is squashed, no halt.
//   - halt detect (Inst==HALT_WORD, no branch, no stall): IR<=Inst, IRPC<=PC, IRValid<=1 for
//     exactly that one cycle, PC holds, state->HALT.
//  HALT: IRValid=0, PC frozen at halt address, Done=1 until Start (or Reset).
//  IDLE: IRValid=0, PC=START_ADDR; Inst ignored.
//  Arithmetic: all PC math unsigned mod 2**A; PC=2**A-1 advances to 0 (wrap, no flag).
//   Relative offset sign-extends naturally at width A (e.g. A=10, BrTarget=10'h3FD is -3).
//  Branch with IRValid=0 (bubble or IDLE/HALT) is ignored.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs CycleCnt[15:0] (increments every RUN cycle) and
//   InstCnt[15:0] (increments when IRValid=1 and Stall=0); both saturate at 16'hFFFF, clear on
//   Reset and on Start. Not defined: ports and counters absent, behaviour otherwise identical.
// TESTING
//  Reset mid-run at PC=5 -> same cycle PC=0, IRValid=0, Busy=0; Start -> PC 0,1,2..., IR=ROM[n]
//   one cycle after PC=n.
//  ROM[0..2]=NOPs, BrTaken with IR@IRPC=2, BrAbs=0, BrTarget=10'h3FD -> next PC=1023? no: 2-3=
//   10'h3FF (wrap); IRValid=0 one cycle; then IR=ROM[1023], PC 0 next.
//  Absolute branch BrTarget=8 from IRPC=4 while Inst=HALT_WORD at PC=5 -> no halt, PC=8.
//  Stall held 3 cycles at PC=6 -> PC, IR, IRPC, IRValid constant; BrTaken during stall ignored.
//  ROM[9]=9'h1FF -> IR=9'h1FF, IRValid=1 one cycle, then Done=1, PC=9 held; Start -> PC=0.
//  FETCH_PERF_CNT_EN: 10-instr program incl. 1 taken branch, 2 stall cycles -> InstCnt equals
//   retired count, CycleCnt equals RUN cycles; counters cleared by next Start.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives PC into a combinational InstROM, registers the returned word
// into IR/IRPC, and sequences start, advance, branch redirect, stall and halt. Optional
// performance counters are built when FETCH_PERF_CNT_EN is defined.
module inst_fetch #(
  parameter int unsigned    A          = 10,
  parameter int unsigned    W          = 9,
  parameter logic [A-1:0]   START_ADDR = '0,
  parameter logic [W-1:0]   HALT_WORD  = '1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Stall,
  input  logic         BrTaken,
  input  logic         BrAbs,
  input  logic [A-1:0] BrTarget,
  input  logic [W-1:0] Inst,
  output logic [A-1:0] PC,
  output logic [W-1:0] IR,
  output logic [A-1:0] IRPC,
  output logic         IRValid,
  output logic         Busy,
  output logic         Done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]  CycleCnt,
  output logic [15:0]  InstCnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam logic [A-1:0] PC_ONE = {{(A-1){1'b0}}, 1'b1};

  state_e       r_state;
  logic [A-1:0] r_pc;
  logic [W-1:0] r_ir;
  logic [A-1:0] r_irpc;
  logic         r_ir_valid;

  logic         w_branch;
  logic         w_start_go;
  logic [A-1:0] w_br_dest;

  // A branch only counts when it refers to a live instruction and execute is not held.
  assign w_branch   = BrTaken && r_ir_valid && !Stall;
  assign w_start_go = Start && (r_state != S_RUN);
  assign w_br_dest  = BrAbs ? BrTarget : (r_irpc + BrTarget);

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of its peers, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_pc       <= START_ADDR;
      r_ir       <= '0;
      r_irpc     <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          r_ir_valid <= 1'b0;
          if (Start) begin
            r_state <= S_RUN;
            r_pc    <= START_ADDR;
          end
        end
        S_RUN: begin
          if (w_branch) begin
            r_pc       <= w_br_dest;
            r_ir_valid <= 1'b0;
          end else if (!Stall) begin
            r_ir       <= Inst;
            r_irpc     <= r_pc;
            r_ir_valid <= 1'b1;
            // The halt word is delivered to IR once; PC stays on it for inspection.
            if (Inst == HALT_WORD) r_state <= S_HALT;
            else                   r_pc    <= r_pc + PC_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign PC      = r_pc;
  assign IR      = r_ir;
  assign IRPC    = r_irpc;
  assign IRValid = r_ir_valid;
  assign Busy    = (r_state == S_RUN);
  assign Done    = (r_state == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_cycle_cnt;
  logic [15:0] r_inst_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else if (w_start_go) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      if (r_state == S_RUN && r_cycle_cnt != 16'hFFFF) r_cycle_cnt <= r_cycle_cnt + 16'd1;
      if (r_ir_valid && !Stall && r_inst_cnt != 16'hFFFF) r_inst_cnt <= r_inst_cnt + 16'd1;
    end
  end

  assign CycleCnt = r_cycle_cnt;
  assign InstCnt  = r_inst_cnt;
`else
  logic w_unused;
  assign w_unused = w_start_go;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed start/branch/stall/halt/reset scenarios
// followed by a randomized run, checked against a cycle model and a fetch scoreboard.
module tb_inst_fetch;
  localparam int A = 10;
  localparam int W = 9;
  localparam logic [W-1:0] HALT = 9'h1FF;

  typedef struct packed {
    logic [A-1:0] pc;
    logic [W-1:0] ir;
  } fetch_t;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic         Stall = 1'b0;
  logic         BrTaken = 1'b0;
  logic         BrAbs = 1'b0;
  logic [A-1:0] BrTarget = '0;
  logic [W-1:0] Inst;
  logic [A-1:0] PC;
  logic [W-1:0] IR;
  logic [A-1:0] IRPC;
  logic         IRValid;
  logic         Busy;
  logic         Done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]  CycleCnt;
  logic [15:0]  InstCnt;
`endif

  logic [W-1:0] rom [0:(1<<A)-1];
  assign Inst = rom[PC];

  inst_fetch #(.A(A), .W(W), .START_ADDR('0), .HALT_WORD(HALT)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .BrTaken(BrTaken),
    .BrAbs(BrAbs), .BrTarget(BrTarget), .Inst(Inst), .PC(PC), .IR(IR), .IRPC(IRPC),
    .IRValid(IRValid), .Busy(Busy), .Done(Done)
`ifdef FETCH_PERF_CNT_EN
    , .CycleCnt(CycleCnt), .InstCnt(InstCnt)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0=idle, 1=run, 2=halt.
  int           m_state;
  logic [A-1:0] m_pc;
  logic [A-1:0] m_irpc;
  logic         m_v;
  logic [15:0]  m_cyc;
  logic [15:0]  m_inst;
  fetch_t       sb[$];

  task automatic model_step();
    fetch_t f;
    if (Start && m_state != 1) begin
      m_cyc  = '0;
      m_inst = '0;
    end else begin
      if (m_state == 1 && m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
      if (m_v && !Stall && m_inst != 16'hFFFF) m_inst = m_inst + 16'd1;
    end
    if (m_state != 1) begin
      m_v = 1'b0;
      if (Start) begin
        m_state = 1;
        m_pc    = '0;
      end
    end else if (BrTaken && m_v && !Stall) begin
      m_pc = BrAbs ? BrTarget : A'(m_irpc + BrTarget);
      m_v  = 1'b0;
    end else if (!Stall) begin
      f.pc = m_pc;
      f.ir = rom[m_pc];
      sb.push_back(f);
      m_irpc = m_pc;
      m_v    = 1'b1;
      if (rom[m_pc] == HALT) m_state = 2;
      else                   m_pc = A'(m_pc + 1);
    end
  endtask

  task automatic tick(input logic st, input logic stl, input logic br, input logic ab,
                      input logic [A-1:0] tg);
    fetch_t f;
    Start = st; Stall = stl; BrTaken = br; BrAbs = ab; BrTarget = tg;
    model_step();
    @(posedge Clk);
    #1;
    check("pc", PC, m_pc);
    check("irvalid", IRValid, m_v);
    check("busy", Busy, m_state == 1);
    check("done", Done, m_state == 2);
    if (sb.size() > 0) begin
      f = sb.pop_front();
      check("ir", IR, f.ir);
      check("irpc", IRPC, f.pc);
    end
`ifdef FETCH_PERF_CNT_EN
    check("cyclecnt", CycleCnt, m_cyc);
    check("instcnt", InstCnt, m_inst);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Asserted between edges to show the reset acts without a clock.
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    m_state = 0; m_pc = '0; m_irpc = '0; m_v = 1'b0; m_cyc = '0; m_inst = '0;
    sb.delete();
    check("rst_pc", PC, 0);
    check("rst_ir", IR, 0);
    check("rst_irpc", IRPC, 0);
    check("rst_irvalid", IRValid, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_cyclecnt", CycleCnt, 0);
    check("rst_instcnt", InstCnt, 0);
`endif
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << A); i++) rom[i] = W'((i * 7 + 3) & 8'hFF);
    #1;
    do_reset();

    // Sequential fetch, then reset in the middle of a run at PC=5.
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    run(5);
    check("a_pc5", PC, 5);
    do_reset();

    // Relative branch backwards past address 0 wraps to the top of the ROM.
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    run(3);
    check("b_irpc2", IRPC, 2);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FD);
    check("b_pc_wrap", PC, 10'h3FF);
    check("b_bubble", IRValid, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("b_ir_top", IR, rom[1023]);
    check("b_pc0", PC, 0);
    run(2);

    // Absolute branch squashes a halt word sitting on Inst.
    rom[5] = HALT;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    run(5);
    check("c_irpc4", IRPC, 4);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 10'd8);
    check("c_pc8", PC, 8);
    check("c_nohalt", Done, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("c_start_ignored", PC, 9);
    rom[5] = 9'h012;

    // Stall with a branch request held, then run into a halt word at 9.
    rom[9] = HALT;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    run(6);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1, 10'h055);
      check("d_stall_pc", PC, 6);
      check("d_stall_irpc", IRPC, 5);
      check("d_stall_v", IRValid, 1);
    end
    run(3);
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("d_ir_halt", IR, HALT);
    check("d_v_halt", IRValid, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("d_done", Done, 1);
    check("d_pc9", PC, 9);
    check("d_v0", IRValid, 0);
    run(2);
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("d_restart_pc", PC, 0);
    check("d_restart_busy", Busy, 1);
    rom[9] = 9'h042;

    // Random traffic with occasional halt words and restarts.
    for (int i = 0; i < (1 << A); i++)
      rom[i] = ($urandom_range(0, 99) < 3) ? HALT : W'($urandom_range(0, 9'h1FE));
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 20), ($urandom_range(0, 1) == 1),
           A'($urandom_range(0, (1 << A) - 1)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
